// File: rtl/shift_pipe.sv
// Pipelined WIDTH-bit shifter (SHL/ROL/SHR/SAR) with carry/zero flags, valid/ready
// handshake with full backpressure, synchronous flush and synchronous reset.
module shift_pipe #(
    parameter int WIDTH   = 18,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] s1,
    input  logic [WIDTH-1:0] s2,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             zero
);

    // Shift results carry one extra bit that captures the last bit shifted out.
    logic [WIDTH:0]          w_shl;
    logic [WIDTH:0]          w_shr;
    logic signed [WIDTH:0]   w_sar;
    logic [WIDTH-1:0]        w_rot_amt;
    logic [2*WIDTH-1:0]      w_rot;
    logic [WIDTH-1:0]        w_res;
    logic                    w_carry;
    logic                    w_zero;
    logic                    w_accept;

    logic [LATENCY-1:0]      w_load;
    logic [LATENCY-1:0]      w_src_valid;
    logic [LATENCY-1:0]      w_src_carry;
    logic [LATENCY-1:0]      w_src_zero;
    logic [WIDTH-1:0]        w_src_res [LATENCY];

    logic [LATENCY-1:0]      r_valid;
    logic [LATENCY-1:0]      r_carry;
    logic [LATENCY-1:0]      r_zero;
    logic [WIDTH-1:0]        r_res [LATENCY];

    assign w_shl     = {1'b0, s1} << s2;
    assign w_shr     = {s1, 1'b0} >> s2;
    assign w_sar     = $signed({s1, 1'b0}) >>> s2;
    assign w_rot_amt = s2 % WIDTH'(WIDTH);
    assign w_rot     = {s1, s1} << w_rot_amt;

    always_comb begin
        w_res   = s1;
        w_carry = 1'b0;
        case (op)
            2'd0: {w_carry, w_res} = w_shl;
            2'd1: begin
                w_res   = w_rot[2*WIDTH-1:WIDTH];
                w_carry = (w_rot_amt != '0) && w_rot[WIDTH];
            end
            2'd2:    {w_res, w_carry} = w_shr;
            default: {w_res, w_carry} = w_sar;
        endcase
    end

    assign w_zero   = (w_res == '0);
    assign in_ready = w_load[0];
    assign w_accept = in_valid && w_load[0] && !flush;

    // A stage may load when the consumer takes the head or any stage from it onward is empty.
    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_stage
            assign w_load[gi] = out_ready || !(&r_valid[LATENCY-1:gi]);
            if (gi == 0) begin : g_head
                assign w_src_valid[gi] = w_accept;
                assign w_src_res[gi]   = w_res;
                assign w_src_carry[gi] = w_carry;
                assign w_src_zero[gi]  = w_zero;
            end else begin : g_body
                assign w_src_valid[gi] = r_valid[gi-1];
                assign w_src_res[gi]   = r_res[gi-1];
                assign w_src_carry[gi] = r_carry[gi-1];
                assign w_src_zero[gi]  = r_zero[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_carry <= '0;
            r_zero  <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_res[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                if (flush) begin
                    r_valid[i] <= 1'b0;
                end else if (w_load[i]) begin
                    r_valid[i] <= w_src_valid[i];
                end
                // Payload only moves with a valid op so the post-reset zeros survive idle cycles.
                if (!flush && w_load[i] && w_src_valid[i]) begin
                    r_res[i]   <= w_src_res[i];
                    r_carry[i] <= w_src_carry[i];
                    r_zero[i]  <= w_src_zero[i];
                end
            end
        end
    end

    assign out_valid = r_valid[LATENCY-1];
    assign res       = r_res[LATENCY-1];
    assign carry     = r_carry[LATENCY-1];
    assign zero      = r_zero[LATENCY-1];

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe (WIDTH=18, LATENCY=2): directed vectors plus a
// queue-based scoreboard fed by a bit-level reference model.
module tb_shift_pipe;
    localparam int W = 18;
    localparam int L = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         carry;
    logic         zero;

    int checks   = 0;
    int failures = 0;
    int n_pop    = 0;
    bit sb_en    = 1'b0;
    logic [W:0] sb_q [$];

    shift_pipe #(.WIDTH(W), .LATENCY(L)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .s1(s1), .s2(s2), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .carry(carry), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // Reference: bit-by-bit from the shift rules; returns {carry, res}.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o);
        int n;
        int r;
        logic [W-1:0] q;
        logic c;
        n = int'(b);
        q = '0;
        c = 1'b0;
        case (o)
            2'd0: begin
                for (int i = 0; i < W; i++) if (i - n >= 0) q[i] = a[i-n];
                if (n >= 1 && n <= W) c = a[W-n];
            end
            2'd1: begin
                r = n % W;
                for (int i = 0; i < W; i++) q[i] = a[(i - r + W) % W];
                c = (r != 0) ? q[0] : 1'b0;
            end
            2'd2: begin
                for (int i = 0; i < W; i++) if (i + n < W) q[i] = a[i+n];
                if (n >= 1 && n <= W) c = a[n-1];
            end
            default: begin
                for (int i = 0; i < W; i++) q[i] = (i + n < W) ? a[i+n] : a[W-1];
                if (n == 0) c = 1'b0;
                else if (n <= W) c = a[n-1];
                else c = a[W-1];
            end
        endcase
        return {c, q};
    endfunction

    // Compare process: every cycle, checks the head result and stall stability.
    initial begin
        logic         prev_stall;
        logic [W-1:0] prev_res;
        logic         prev_carry;
        logic         prev_zero;
        logic [W:0]   e;
        prev_stall = 1'b0;
        prev_res   = '0;
        prev_carry = 1'b0;
        prev_zero  = 1'b0;
        forever begin
            @(negedge clk);
            if (sb_en) begin
                if (prev_stall)
                    chk(out_valid && res == prev_res && carry == prev_carry && zero == prev_zero,
                        "hold_stable", {out_valid, carry, zero, res}, {1'b1, prev_carry, prev_zero, prev_res});
                if (out_valid) begin
                    chk(sb_q.size() > 0, "out_expected", 64'(sb_q.size()), 64'd1);
                    if (sb_q.size() > 0) begin
                        e = sb_q[0];
                        chk({carry, res} == e && zero == (e[W-1:0] == '0), "scoreboard",
                            {zero, carry, res}, {(e[W-1:0] == '0), e});
                    end
                end
                prev_stall = out_valid && !out_ready && !rst && !flush;
                prev_res   = res;
                prev_carry = carry;
                prev_zero  = zero;
                if (rst || flush) begin
                    sb_q.delete();
                end else begin
                    if (out_valid && out_ready && sb_q.size() > 0) begin
                        void'(sb_q.pop_front());
                        n_pop++;
                    end
                    if (in_valid && in_ready) sb_q.push_back(model(s1, s2, op));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    // Directed single op with out_ready=1 from an empty pipe; checks exact latency.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o,
                          input logic [W-1:0] er, input logic ec, input logic ez, input string nm);
        logic [W:0] m;
        m = model(a, b, o);
        chk(m == {ec, er}, {nm, "_model"}, 64'(m), 64'({ec, er}));
        s1 = a; s2 = b; op = o; in_valid = 1'b1; out_ready = 1'b1;
        chk(in_ready == 1'b1, {nm, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk(out_valid == 1'b0, {nm, "_early"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk(out_valid && res == er && carry == ec && zero == ez, nm,
            {out_valid, zero, carry, res}, {1'b1, ez, ec, er});
        @(posedge clk); #1;
    endtask

    task automatic drain(input string nm);
        int cyc;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk(sb_q.size() == 0, nm, 64'(sb_q.size()), 64'd0);
    endtask

    logic [W-1:0] t_s1 [8] = '{18'h2A5C3, 18'h3FFFF, 18'h00F0F, 18'h20000, 18'h12345, 18'h3C3C3, 18'h00001, 18'h1FFFF};
    logic [W-1:0] t_s2 [8] = '{18'd5, 18'd3, 18'd18, 18'd7, 18'd35, 18'd0, 18'd17, 18'd100};
    logic [1:0]   t_op [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3, 2'd0, 2'd2};
    bit           pat  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        int idx;
        int cyc;
        int cnt;
        int p0;
        bit acc;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; s1 = '0; s2 = '0; op = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        sb_en = 1'b1;
        chk({out_valid, carry, zero, res} == '0, "reset_outputs", {out_valid, carry, zero, res}, 64'd0);
        chk(in_ready == 1'b1, "reset_in_ready", 64'(in_ready), 64'd1);

        run_op(18'h00001, 18'd17,    2'd0, 18'h20000, 1'b0, 1'b0, "shl_17");
        run_op(18'h00001, 18'd18,    2'd0, 18'h00000, 1'b1, 1'b1, "shl_18");
        run_op(18'h20000, 18'd4,     2'd3, 18'h3E000, 1'b0, 1'b0, "sar_4");
        run_op(18'h20000, 18'd40,    2'd3, 18'h3FFFF, 1'b1, 1'b0, "sar_40");
        run_op(18'h3FFFF, 18'd18,    2'd2, 18'h00000, 1'b1, 1'b1, "shr_18");
        run_op(18'h3FFFF, 18'h3FFFF, 2'd2, 18'h00000, 1'b0, 1'b1, "shr_max");
        run_op(18'h20001, 18'd1,     2'd1, 18'h00003, 1'b1, 1'b0, "rol_1");
        run_op(18'h20001, 18'd19,    2'd1, 18'h00003, 1'b1, 1'b0, "rol_19");
        run_op(18'h20001, 18'd18,    2'd1, 18'h20001, 1'b0, 1'b0, "rol_18");
        run_op(18'h12345, 18'd0,     2'd0, 18'h12345, 1'b0, 1'b0, "shl_0");

        // Back-to-back stream under an out_ready stall pattern.
        p0 = n_pop; idx = 0; cyc = 0;
        while (idx < 8 && cyc < 200) begin
            s1 = t_s1[idx]; s2 = t_s2[idx]; op = t_op[idx];
            in_valid = 1'b1; out_ready = pat[cyc % 8];
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        chk(idx == 8, "stream_issued", 64'(idx), 64'd8);
        drain("stream_drain");
        chk(n_pop - p0 == 8, "stream_count", 64'(n_pop - p0), 64'd8);

        // Backpressure: exactly LATENCY accepts with the consumer stalled.
        out_ready = 1'b0; cnt = 0;
        for (int k = 0; k < 6; k++) begin
            s1 = 18'h00100 + 18'(k); s2 = 18'(k); op = 2'(k); in_valid = 1'b1;
            @(negedge clk); if (in_ready) cnt++;
            @(posedge clk); #1;
        end
        chk(cnt == L, "bp_accepts", 64'(cnt), 64'(L));
        drain("bp_drain");

        // Flush with a full pipe and a request presented.
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s1 = 18'h0ABCD; s2 = 18'(k + 1); op = 2'd0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        flush = 1'b1; in_valid = 1'b1; s1 = 18'h3FFFF; s2 = 18'd2; op = 2'd1;
        @(negedge clk);
        chk(in_ready == 1'b0, "flush_full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk(out_valid == 1'b0, "flush_full_out", 64'(out_valid), 64'd0);
        // Flush on an empty pipe must still refuse the request.
        flush = 1'b1; in_valid = 1'b1; s1 = 18'h00055; s2 = 18'd1; op = 2'd0;
        @(negedge clk);
        chk(in_ready == 1'b1, "flush_empty_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk(out_valid == 1'b0, "flush_empty_out1", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk(out_valid == 1'b0, "flush_empty_out2", 64'(out_valid), 64'd0);
        run_op(18'h00F00, 18'd4, 2'd2, 18'h000F0, 1'b0, 1'b0, "post_flush");

        // Reset with a full pipe.
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s1 = 18'h3FFFF; s2 = 18'(k + 3); op = 2'd3; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk({out_valid, carry, zero, res} == '0, "rst_full_outputs", {out_valid, carry, zero, res}, 64'd0);
        chk(in_ready == 1'b1, "rst_full_in_ready", 64'(in_ready), 64'd1);
        run_op(18'h00003, 18'd17, 2'd1, 18'h20001, 1'b1, 1'b0, "post_rst");

        chk(sb_q.size() == 0, "final_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
Parametrised, pipelined successor to the team's combinational 18-bit shifter. Performs logical left, rotate left, logical right and arithmetic right shifts on WIDTH-bit operands. Adds carry-out and zero flags, a valid/ready handshake with full backpressure, and a synchronous flush. Sits between the ALU operand latches and the writeback mux, and is used by both the datapath and the address-generation unit.

Parameters:
WIDTH, 18, operand/result width in bits (2..64).
LATENCY, 2, pipeline register stages from accept to result-valid (1..4).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
flush  input  1  synchronous pipeline clear; drops all in-flight operations.
in_valid  input  1  request present.
in_ready  output  1  request accepted this cycle when in_valid && in_ready.
s1  input  WIDTH  value to shift.
s2  input  WIDTH  shift amount, unsigned; the full width is significant.
op  input  2  0=SHL, 1=ROL, 2=SHR, 3=SAR.
out_valid  output  1  result present.
out_ready  input  1  consumer takes result when out_valid && out_ready.
res  output  WIDTH  shifted result.
carry  output  1  last bit shifted out (see rules).
zero  output  1  res == 0.

Behaviour:
- Reset: all stage valid bits 0; out_valid=0, res=0, carry=0, zero=0; in_ready=1 in the cycle after rst deasserts.
- Pipeline: LATENCY stages, each with a valid bit and payload. A stage loads when it is empty or its contents move on in the same cycle. Last stage empties on out_ready. in_ready = !v[0] || stage 0 advances (combinational from out_ready through the stall chain).
- Latency: accepted at edge t, with no stall -> out_valid=1 with the result after edge t+LATENCY-1. Throughput is 1 per cycle when out_ready=1. Order is preserved; no drops or duplicates under any stall pattern.
- Output payload (res, carry, zero) holds stable while out_valid && !out_ready.
- Let n = s2 as an unsigned integer.
  - SHL: res = s1 << n; 0 if n >= WIDTH. carry = s1[WIDTH-n] for 1 <= n <= WIDTH, else 0.
  - SHR: res = s1 >> n; 0 if n >= WIDTH. carry = s1[n-1] for 1 <= n <= WIDTH, else 0.
  - SAR: sign-filled right shift. For n >= WIDTH, res = all bits s1[WIDTH-1]. carry = s1[n-1] for 1 <= n <= WIDTH; carry = s1[WIDTH-1] for n > WIDTH; carry = 0 for n = 0.
  - ROL: r = n mod WIDTH (true modulo, WIDTH need not be a power of 2); res = rotate-left of s1 by r. carry = res[0] if r != 0, else 0.
- n = 0 for any op: res = s1, carry = 0.
- zero is computed from the final res.
- The split of computation across stages is implementation-free. Only latency, handshake and values are specified.
- flush: at the edge, all valid bits clear and any request presented that cycle is not accepted. in_ready still reflects stall state combinationally. out_valid=0 the next cycle.
- rst has priority over flush; flush has priority over accept. Reset mid-operation discards everything, with no partial results.
- Payload registers of invalid stages are don't-care, except that res/carry/zero are 0 after reset until the first result.

Test Plan:
- WIDTH=18, LATENCY=2, out_ready=1: SHL s1=0x00001 s2=17 -> res=0x20000, carry=0, zero=0, out_valid 2 cycles after accept. SHL s1=0x00001 s2=18 -> res=0, carry=1, zero=1.
- SAR s1=0x20000 s2=4 -> res=0x3E000, carry=0. SAR s1=0x20000 s2=40 -> res=0x3FFFF, carry=1. SHR s1=0x3FFFF s2=18 -> res=0, carry=1. SHR s2=0x3FFFF -> res=0, carry=0.
- ROL s1=0x20001 s2=1 -> res=0x00003, carry=1. ROL s2=19 -> same result. ROL s2=18 -> res=0x20001, carry=0.
- Back-to-back stream of 8 ops, out_ready toggled with pattern 1,0,0,1,0,1,1,0 -> results in order, none lost or duplicated, payload stable during stalls. With out_ready=0, in_ready falls after exactly LATENCY accepts.
- Two ops in flight, then flush=1 together with in_valid=1 -> next cycle out_valid=0, neither in-flight op nor the flushed request ever appears. The op issued after the flush returns correctly.
- rst asserted for 1 cycle with a full pipe -> out_valid=0, res=0, carry=0, zero=0 after the edge. Normal operation resumes on the next accept.
